// File: rtl/seg7_pkg.sv
// Shared types and segment patterns for the time display path.
// Segment bits are {g,f,e,d,c,b,a} and active-low.
package seg7_pkg;

  typedef logic [6:0] seg7_t;
  typedef logic [7:0] field_t;

  localparam seg7_t SEG_BLANK = 7'h7F;
  localparam seg7_t SEG_DASH  = 7'h3F;

  localparam seg7_t SEG_DIGITS [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/seg7_field_enc.sv
// Converts one two-digit binary field into tens/ones segment patterns.
module seg7_field_enc
  import seg7_pkg::*;
(
  input  field_t     value,
  input  logic       blank_lead,
  input  logic       blank,
  output seg7_t      tens,
  output seg7_t      ones
);

  logic [3:0] tens_v;
  logic [3:0] ones_v;

  always_comb begin
    tens_v = 4'(value / 8'd10);
    ones_v = 4'(value % 8'd10);
    tens   = SEG_BLANK;
    ones   = SEG_BLANK;
    // Blink wins over everything so an edited field fully disappears.
    if (blank) begin
      tens = SEG_BLANK;
      ones = SEG_BLANK;
    end else if (value > 8'd99) begin
      tens = SEG_DASH;
      ones = SEG_DASH;
    end else begin
      tens = (blank_lead && tens_v == 4'd0) ? SEG_BLANK : SEG_DIGITS[tens_v];
      ones = SEG_DIGITS[ones_v];
    end
  end

endmodule

// File: rtl/seg7_display_mux.sv
// Source select, per-field 7-segment conversion with blinking, and a
// scanned digit output for multiplexed display boards.
module seg7_display_mux
  import seg7_pkg::*;
#(
  parameter int N_SRC       = 4,
  parameter int N_FIELDS    = 3,
  parameter int BLINK_TICKS = 250,
  parameter int SEL_W       = $clog2(N_SRC)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      tick_en,
  input  logic [N_SRC*N_FIELDS*8-1:0] src_data,
  input  logic [SEL_W-1:0]          sel,
  input  logic [N_FIELDS-1:0]       blink_field,
  input  logic                      blank_lead,
  output logic [N_FIELDS*14-1:0]    seg_static,
  output logic [6:0]                seg_scan,
  output logic [2*N_FIELDS-1:0]     digit_n
);

  localparam int FW    = N_FIELDS * 8;
  localparam int NDIG  = 2 * N_FIELDS;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [FW-1:0]          sel_data_q,    sel_data_d;
  logic [N_FIELDS-1:0]    blink_field_q;
  logic [CNT_W-1:0]       blink_cnt_q,   blink_cnt_d;
  logic                   blink_phase_q, blink_phase_d;
  logic [IDX_W-1:0]       scan_idx_q,    scan_idx_d;
  logic [N_FIELDS*14-1:0] seg_static_q,  seg_static_d;
  logic [6:0]             seg_scan_q,    seg_scan_d;
  logic [NDIG-1:0]        digit_n_q,     digit_n_d;

  // Out-of-range selects match no slice, so the previous data is held.
  always_comb begin
    sel_data_d = sel_data_q;
    for (int k = 0; k < N_SRC; k++) begin
      if (sel == SEL_W'(k)) sel_data_d = src_data[k*FW +: FW];
    end
  end

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (blink_field != blink_field_q) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (tick_en) begin
      if (blink_cnt_q == CNT_W'(BLINK_TICKS - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Next-phase drives the blank so a blink restart shows up on the same edge.
  for (genvar f = 0; f < N_FIELDS; f++) begin : g_field
    seg7_field_enc u_enc (
      .value      (sel_data_q[f*8 +: 8]),
      .blank_lead (blank_lead),
      .blank      (blink_phase_d & blink_field[f]),
      .tens       (seg_static_d[f*14+7 +: 7]),
      .ones       (seg_static_d[f*14 +: 7])
    );
  end

  always_comb begin
    scan_idx_d = scan_idx_q;
    if (tick_en) begin
      scan_idx_d = (scan_idx_q == IDX_W'(NDIG - 1)) ? '0 : scan_idx_q + 1'b1;
    end
    digit_n_d  = ~({{(NDIG-1){1'b0}}, 1'b1} << scan_idx_q);
    seg_scan_d = seg_static_q[scan_idx_q*7 +: 7];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel_data_q    <= '0;
      blink_field_q <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      scan_idx_q    <= '0;
      seg_static_q  <= {NDIG{SEG_BLANK}};
      seg_scan_q    <= SEG_BLANK;
      digit_n_q     <= '1;
    end else begin
      sel_data_q    <= sel_data_d;
      blink_field_q <= blink_field;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      scan_idx_q    <= scan_idx_d;
      seg_static_q  <= seg_static_d;
      seg_scan_q    <= seg_scan_d;
      digit_n_q     <= digit_n_d;
    end
  end

  assign seg_static = seg_static_q;
  assign seg_scan   = seg_scan_q;
  assign digit_n    = digit_n_q;

endmodule

// File: tb/tb_seg7_display_mux.sv
// Randomised and directed bench for seg7_display_mux against a behavioural model.
module tb_seg7_display_mux;

  localparam int N_SRC = 3;
  localparam int N_FIELDS = 3;
  localparam int BT = 4;
  localparam int FW = N_FIELDS * 8;
  localparam int NDIG = 2 * N_FIELDS;

  logic                        clock = 1'b0;
  logic                        reset = 1'b1;
  logic                        tick_en = 1'b0;
  logic [N_SRC*FW-1:0]         src_data = '0;
  logic [1:0]                  sel = '0;
  logic [N_FIELDS-1:0]         blink_field = '0;
  logic                        blank_lead = 1'b0;
  logic [N_FIELDS*14-1:0]      seg_static;
  logic [6:0]                  seg_scan;
  logic [NDIG-1:0]             digit_n;

  seg7_display_mux #(.N_SRC(N_SRC), .N_FIELDS(N_FIELDS), .BLINK_TICKS(BT)) dut (
    .clock(clock), .reset(reset), .tick_en(tick_en), .src_data(src_data),
    .sel(sel), .blink_field(blink_field), .blank_lead(blank_lead),
    .seg_static(seg_static), .seg_scan(seg_scan), .digit_n(digit_n)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] segs [10];
  logic [FW-1:0]          m_sel;
  logic [N_FIELDS-1:0]    m_bf;
  int                     m_bticks;
  int                     m_sticks;
  logic [N_FIELDS*14-1:0] m_static;
  logic [6:0]             m_scan;
  logic [NDIG-1:0]        m_dn;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [13:0] enc(input logic [7:0] v, input logic bl, input logic blank);
    int t, o;
    if (blank) return {7'h7F, 7'h7F};
    if (v > 99) return {7'h3F, 7'h3F};
    t = int'(v) / 10;
    o = int'(v) % 10;
    return {(bl && t == 0) ? 7'h7F : segs[t], segs[o]};
  endfunction

  function automatic int phase();
    return (m_bticks / BT) % 2;
  endfunction

  task automatic model_reset();
    m_sel = '0; m_bf = '0; m_bticks = 0; m_sticks = 0;
    m_static = {NDIG{7'h7F}}; m_scan = 7'h7F; m_dn = '1;
  endtask

  task automatic model_edge();
    int old_idx;
    logic [N_FIELDS*14-1:0] old_static;
    logic [FW-1:0] old_sel;
    old_idx = m_sticks % NDIG;
    old_static = m_static;
    old_sel = m_sel;
    if (blink_field != m_bf) m_bticks = 0;
    else if (tick_en) m_bticks++;
    m_bf = blink_field;
    for (int f = 0; f < N_FIELDS; f++)
      m_static[f*14 +: 14] = enc(old_sel[f*8 +: 8], blank_lead, (phase() == 1) && blink_field[f]);
    m_scan = old_static[old_idx*7 +: 7];
    m_dn = ~(NDIG'(1) << old_idx);
    if (int'(sel) < N_SRC) m_sel = src_data[int'(sel)*FW +: FW];
    if (tick_en) m_sticks++;
  endtask

  task automatic cmp_all();
    check("seg_static", 64'(seg_static), 64'(m_static));
    check("seg_scan", 64'(seg_scan), 64'(m_scan));
    check("digit_n", 64'(digit_n), 64'(m_dn));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    if (reset) model_reset();
    else model_edge();
    cmp_all();
  endtask

  task automatic set_src(input int k, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    src_data[k*FW +: FW] = {h, m, s};
  endtask

  initial begin
    segs = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    model_reset();

    // reset and first display
    set_src(0, 8'h17, 8'h2D, 8'h05);
    set_src(2, 8'd12, 8'd150, 8'd30);
    sel = 2'd0;
    repeat (2) step();
    check("rst_static", 64'(seg_static), 64'({NDIG{7'h7F}}));
    #2 reset = 1'b0;
    step();
    step();
    check("hour23", 64'(seg_static[41:28]), 64'({7'h24, 7'h30}));
    check("min45", 64'(seg_static[27:14]), 64'({7'h19, 7'h12}));
    check("sec05", 64'(seg_static[13:0]), 64'({7'h40, 7'h12}));

    // source switch with out-of-range minute, then invalid select
    #2 sel = 2'd2;
    step();
    check("min_lag1", 64'(seg_static[27:14]), 64'({7'h19, 7'h12}));
    step();
    check("min_dash", 64'(seg_static[27:14]), 64'({7'h3F, 7'h3F}));
    #2 sel = 2'd3;
    set_src(0, 8'd1, 8'd2, 8'd3);
    repeat (4) step();
    check("sel3_hold", 64'(seg_static[27:14]), 64'({7'h3F, 7'h3F}));

    // leading-zero blanking
    #2 sel = 2'd0; blank_lead = 1'b1; set_src(0, 8'd10, 8'd20, 8'd7);
    repeat (2) step();
    check("sec7_blank", 64'(seg_static[13:0]), 64'({7'h7F, 7'h78}));
    #2 set_src(0, 8'd10, 8'd20, 8'd0);
    repeat (2) step();
    check("sec0_blank", 64'(seg_static[13:0]), 64'({7'h7F, 7'h40}));

    // blinking with continuous ticks, then edit a different field mid-blank
    #2 blank_lead = 1'b0; tick_en = 1'b1; blink_field = 3'b100;
    repeat (12) step();
    for (int i = 0; i < 2 * BT && phase() != 1; i++) step();
    step();
    check("hour_blank", 64'(seg_static[41:28]), 64'({7'h7F, 7'h7F}));
    #2 blink_field = 3'b010;
    step();
    check("min_visible", 64'(seg_static[27:14]), 64'({7'h24, 7'h40}));
    check("hour_visible", 64'(seg_static[41:28]), 64'({7'h79, 7'h40}));
    repeat (10) step();

    // scan with tick every third clock
    #2 blink_field = '0;
    for (int i = 0; i < 45; i++) begin
      tick_en = (i % 3 == 0);
      step();
      #2;
    end

    // async reset mid-scan
    tick_en = 1'b1;
    for (int i = 0; i < 2 * NDIG && (m_sticks % NDIG) != 4; i++) step();
    step();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("async_dn", 64'(digit_n), 64'({NDIG{1'b1}}));
    check("async_scan", 64'(seg_scan), 64'(7'h7F));
    check("async_static", 64'(seg_static), 64'({NDIG{7'h7F}}));
    step();
    #2 reset = 1'b0;
    step();
    check("scan_restart", 64'(digit_n), 64'(6'b111110));

    // randomised traffic
    for (int i = 0; i < 300; i++) begin
      #2;
      if ($urandom_range(0, 3) == 0)
        for (int k = 0; k < N_SRC; k++)
          set_src(k, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 120)), 8'($urandom_range(0, 99)));
      if ($urandom_range(0, 7) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) blink_field = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) blank_lead = ~blank_lead;
      tick_en = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
